// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolve unit: condition codes,
// flag layout, predictor counter encodings, FSM states and condition evaluation.
package branch_resolve_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Flag vector layout is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] PHT_SNT = 2'b00;
  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_WT  = 2'b10;
  localparam logic [1:0] PHT_ST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_ISSUE     = 2'd2
  } bru_state_e;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, res;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c & !z;
      COND_LS: res = !c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pht.sv
// Bimodal pattern history table: DEPTH 2-bit saturating counters, one
// combinational read port for IF and one update port driven at EX resolve.
module bimodal_pht
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= PHT_WNT;
    end else if (upd_en) begin
      if (upd_taken && ctr_q[upd_idx] != PHT_ST)
        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
      else if (!upd_taken && ctr_q[upd_idx] != PHT_SNT)
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
    end
  end

  // Reads see the pre-update value when the same entry is written this cycle
  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: flag register with forwarding, condition
// evaluation, bimodal prediction, mispredict redirect with optional delay slot.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int PHT_DEPTH   = 16,
  parameter int DELAY_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  input  logic              ex_valid,
  input  logic              ex_B,
  input  logic              ex_BL,
  input  logic [3:0]        ex_cond,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              slot_branch_err,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [3:0]        flag_q;
  logic [3:0]        flags_eff;
  logic              is_branch;
  logic              resolve;
  logic              taken;
  logic              mispredict;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] correct_pc;
  bru_state_e        state_q, state_d;
  logic              redirect_set;
  logic              unused_if_pc_bits;

  assign flags_eff  = flag_we ? flags_in : flag_q;
  assign is_branch  = ex_B | ex_BL;
  assign resolve    = ex_valid & is_branch & (state_q == ST_IDLE);
  assign taken      = cond_eval(ex_cond, flags_eff);
  assign mispredict = resolve & (taken != ex_pred_taken);
  assign seq_pc     = ex_pc + ADDR_W'(4 * (1 + DELAY_SLOTS));
  assign correct_pc = taken ? ex_target : seq_pc;

  assign unused_if_pc_bits = ^{if_pc[ADDR_W-1:IDX_W+2], if_pc[1:0]};

  bimodal_pht #(
    .DEPTH (PHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_pht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_taken  (if_pred_taken),
    .upd_en    (resolve),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

  // Without a delay slot the redirect fires straight from IDLE; with one, the
  // FSM waits for the slot instruction to enter EX before flushing.
  always_comb begin
    state_d      = state_q;
    redirect_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          if (DELAY_SLOTS == 0) redirect_set = 1'b1;
          else                  state_d      = ST_WAIT_SLOT;
        end
      end
      ST_WAIT_SLOT: begin
        if (ex_valid) begin
          state_d      = ST_ISSUE;
          redirect_set = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      flag_q          <= 4'd0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      link_we         <= 1'b0;
      link_addr       <= '0;
      slot_branch_err <= 1'b0;
      mispredict_cnt  <= '0;
    end else begin
      state_q        <= state_d;
      redirect_valid <= redirect_set;
      link_we        <= resolve & ex_BL & taken;
      if (flag_we) flag_q <= flags_in;
      // Correct PC is captured at resolve and held until the redirect issues
      if (mispredict) redirect_pc <= correct_pc;
      if (resolve && ex_BL && taken) link_addr <= seq_pc;
      if (state_q == ST_WAIT_SLOT && ex_valid && is_branch) slot_branch_err <= 1'b1;
      if (mispredict && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one instance without and one with a
// delay slot, driven from shared inputs and checked with immediate assertions.
module tb_branch_resolve_unit;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              flag_we;
  logic [3:0]        flags_in;
  logic              ex_valid;
  logic              ex_B;
  logic              ex_BL;
  logic [3:0]        ex_cond;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] if_pc;

  logic              pred_0, rv_0, lwe_0, err_0;
  logic [ADDR_W-1:0] rpc_0, laddr_0;
  logic [CNT_W-1:0]  cnt_0;
  logic              pred_1, rv_1, lwe_1, err_1;
  logic [ADDR_W-1:0] rpc_1, laddr_1;
  logic [CNT_W-1:0]  cnt_1;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .PHT_DEPTH(16), .DELAY_SLOTS(0), .CNT_W(CNT_W)) u_ds0 (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flags_in(flags_in),
    .ex_valid(ex_valid), .ex_B(ex_B), .ex_BL(ex_BL), .ex_cond(ex_cond),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .if_pc(if_pc), .if_pred_taken(pred_0), .redirect_valid(rv_0),
    .redirect_pc(rpc_0), .link_we(lwe_0), .link_addr(laddr_0),
    .slot_branch_err(err_0), .mispredict_cnt(cnt_0)
  );

  branch_resolve_unit #(.ADDR_W(ADDR_W), .PHT_DEPTH(16), .DELAY_SLOTS(1), .CNT_W(CNT_W)) u_ds1 (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flags_in(flags_in),
    .ex_valid(ex_valid), .ex_B(ex_B), .ex_BL(ex_BL), .ex_cond(ex_cond),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .if_pc(if_pc), .if_pred_taken(pred_1), .redirect_valid(rv_1),
    .redirect_pc(rpc_1), .link_we(lwe_1), .link_addr(laddr_1),
    .slot_branch_err(err_1), .mispredict_cnt(cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_B     = 1'b0;
    ex_BL    = 1'b0;
    flag_we  = 1'b0;
  endtask

  task automatic br(input logic [31:0] pc, input logic [31:0] tgt, input logic [3:0] cond,
                    input logic pred, input logic bl);
    ex_valid      = 1'b1;
    ex_B          = !bl;
    ex_BL         = bl;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_cond       = cond;
    ex_pred_taken = pred;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flags_in = 4'd0; ex_cond = 4'd0; ex_pc = '0; ex_target = '0;
    ex_pred_taken = 1'b0; if_pc = '0;
    idle();
    #2;
    chk("rst_pred_0", pred_0, 0);   chk("rst_rv_0", rv_0, 0);   chk("rst_rpc_0", rpc_0, 0);
    chk("rst_lwe_0", lwe_0, 0);     chk("rst_laddr_0", laddr_0, 0);
    chk("rst_err_0", err_0, 0);     chk("rst_cnt_0", cnt_0, 0);
    chk("rst_pred_1", pred_1, 0);   chk("rst_rv_1", rv_1, 0);   chk("rst_cnt_1", cnt_1, 0);
    tick();
    rst_n = 1'b1;

    // Flag forwarding into an EQ branch (no delay slot instance)
    flag_we = 1'b1; flags_in = 4'b0100;
    br(32'h10, 32'h100, 4'd0, 1'b0, 1'b0);
    tick();
    chk("fwd_rv", rv_0, 1); chk("fwd_rpc", rpc_0, 32'h100); chk("fwd_cnt", cnt_0, 1);
    idle(); tick();
    chk("fwd_pulse_end", rv_0, 0);

    // Signed compares
    flag_we = 1'b1; flags_in = 4'b1001;
    br(32'h20, 32'h400, 4'd12, 1'b1, 1'b0);
    tick();
    chk("gt_taken_no_redir", rv_0, 0); chk("gt_cnt", cnt_0, 1);
    flag_we = 1'b1; flags_in = 4'b1000;
    br(32'h24, 32'h500, 4'd10, 1'b1, 1'b0);
    tick();
    chk("ge_nt_rv", rv_0, 1); chk("ge_nt_rpc", rpc_0, 32'h28); chk("ge_cnt", cnt_0, 2);
    flag_we = 1'b0; flags_in = 4'b0000;
    br(32'h30, 32'h600, 4'd11, 1'b0, 1'b0);
    tick();
    chk("lt_flagreg_rv", rv_0, 1); chk("lt_flagreg_rpc", rpc_0, 32'h600); chk("lt_cnt", cnt_0, 3);
    idle(); tick();

    // PHT training at 0x40
    if_pc = 32'h40; #1;
    chk("pht_init", pred_0, 0);
    br(32'h40, 32'h80, 4'd14, 1'b1, 1'b0);
    #1;
    chk("pht_same_cycle_old", pred_0, 0);
    tick(); chk("pht_t1", pred_0, 1);
    tick(); chk("pht_t2", pred_0, 1);
    tick(); chk("pht_t3", pred_0, 1);
    tick(); chk("pht_t4", pred_0, 1);
    idle();
    if_pc = 32'h80; #1; chk("pht_alias", pred_0, 1);
    if_pc = 32'h44; #1; chk("pht_other_idx", pred_0, 0);
    if_pc = 32'h40;
    br(32'h40, 32'h80, 4'd15, 1'b0, 1'b0);
    tick(); chk("pht_sat_nt1", pred_0, 1);
    tick(); chk("pht_sat_nt2", pred_0, 0);
    chk("pht_cnt", cnt_0, 3);
    idle();

    // Delay slot: mispredicted BL, two bubbles, then the slot instruction
    do_reset();
    br(32'h200, 32'h300, 4'd14, 1'b0, 1'b1);
    tick();
    chk("ds_lwe", lwe_1, 1); chk("ds_laddr", laddr_1, 32'h208); chk("ds_rv_early", rv_1, 0);
    chk("ds0_laddr", laddr_0, 32'h204); chk("ds0_rv", rv_0, 1); chk("ds0_rpc", rpc_0, 32'h300);
    idle(); tick();
    chk("ds_bub1_rv", rv_1, 0); chk("ds_lwe_pulse", lwe_1, 0);
    tick();
    chk("ds_bub2_rv", rv_1, 0);
    ex_valid = 1'b1; tick();
    chk("ds_issue_rv", rv_1, 1); chk("ds_issue_rpc", rpc_1, 32'h300);
    idle(); tick();
    chk("ds_pulse_end", rv_1, 0); chk("ds_cnt", cnt_1, 1);

    // Branch inside a delay slot
    br(32'h244, 32'h500, 4'd14, 1'b0, 1'b0);
    tick();
    chk("sb_lwe_b_only", lwe_1, 0);
    br(32'h284, 32'h900, 4'd15, 1'b1, 1'b1);
    tick();
    chk("sb_err", err_1, 1); chk("sb_rv", rv_1, 1); chk("sb_rpc", rpc_1, 32'h500);
    chk("sb_cnt", cnt_1, 2); chk("sb_no_link", lwe_1, 0);
    idle();
    if_pc = 32'h284; #1; chk("sb_pht_unchanged", pred_1, 1);
    tick();
    chk("sb_err_sticky", err_1, 1); chk("sb_rv_end", rv_1, 0);

    // Correct prediction stays in IDLE, so a following branch still resolves
    br(32'h300, 32'h800, 4'd14, 1'b1, 1'b0);
    tick();
    chk("cp_no_redir", rv_1, 0);
    br(32'h304, 32'h800, 4'd15, 1'b1, 1'b0);
    tick();
    chk("cp_next_resolves", cnt_1, 3);
    idle(); tick();
    ex_valid = 1'b1; tick();
    chk("cp_rv", rv_1, 1); chk("cp_rpc", rpc_1, 32'h30C);
    idle(); tick();

    // Reset while waiting for the delay slot
    br(32'h400, 32'h700, 4'd14, 1'b0, 1'b0);
    tick();
    idle();
    if_pc = 32'h400;
    rst_n = 1'b0; #1;
    chk("mr_rv", rv_1, 0); chk("mr_pred", pred_1, 0); chk("mr_err", err_1, 0);
    chk("mr_cnt", cnt_1, 0); chk("mr_lwe", lwe_1, 0); chk("mr_rpc", rpc_1, 0);
    tick();
    rst_n = 1'b1;
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_redirect", rv_1, 0);
    end
    br(32'h400, 32'h700, 4'd14, 1'b1, 1'b0);
    tick();
    chk("mr_pht_was_wnt", pred_1, 1); chk("mr_cnt_after", cnt_1, 0);
    idle();

    // Mispredict counter saturation (no delay slot instance mispredicts every cycle)
    do_reset();
    br(32'h10, 32'h20, 4'd14, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_fffe", cnt_0, 16'hFFFE);
    tick(); chk("cnt_ffff", cnt_0, 16'hFFFF);
    tick(); chk("cnt_hold", cnt_0, 16'hFFFF);
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
